// File: rtl/store_pkg.sv
// Shared encodings for the narrow-store path: access sizes, error codes, FSM states
// and the alignment rule used to classify requests.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_SIZE     = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Places the right-justified store value onto byte lanes across a two-word window;
// the low word feeds the first beat and the high word a possible second beat.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [63:0] shifted,
    output logic [7:0]  lanes
);

    logic [3:0]  mask;
    logic [31:0] kept;

    always_comb begin
        mask = 4'b0000;
        kept = 32'h0;
        case (size)
            SZ_BYTE: begin mask = 4'b0001; kept = {24'h0, data[7:0]};  end
            SZ_HALF: begin mask = 4'b0011; kept = {16'h0, data[15:0]}; end
            SZ_WORD: begin mask = 4'b1111; kept = data;                end
            default: begin mask = 4'b0000; kept = 32'h0;               end
        endcase
        lanes   = {4'b0000, mask} << off;
        // Bits above the stored size are dropped so disabled lanes stay zero.
        shifted = {32'h0, kept} << {off, 3'b000};
    end

endmodule

// File: rtl/store_narrow.sv
// Converts byte/halfword/word store requests into word-aligned memory beats with byte enables.
// Define STORE_MISALIGN_SPLIT_EN to split misaligned stores into two beats instead of erroring.
module store_narrow
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        err_valid,
    output logic [1:0]  err_code
);

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  hi_be_q, hi_be_d;
    logic        split_q, split_d;
    logic        err_valid_q, err_valid_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [63:0] al_shifted;
    logic [7:0]  al_lanes;
    logic        misal;
    logic        accept;

    store_lane_align u_align (
        .size    (req_size),
        .off     (req_addr[1:0]),
        .data    (req_data),
        .shifted (al_shifted),
        .lanes   (al_lanes)
    );

    assign misal     = is_misaligned(req_size, req_addr[1:0]);
    // A split holds off new requests until its second beat is on the bus.
    assign req_ready = (state_q == ST_IDLE) ||
                       (mem_ready && ((state_q == ST_BEAT2) ||
                                      ((state_q == ST_BEAT1) && !split_q)));
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
        split_d     = split_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;

        if (mem_ready && (state_q != ST_IDLE)) begin
            if ((state_q == ST_BEAT1) && split_q) begin
                state_d = ST_BEAT2;
                addr_d  = addr_q + 32'd4;
                wdata_d = hi_wdata_q;
                be_d    = hi_be_q;
                split_d = 1'b0;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (accept) begin
            state_d = ST_IDLE;
            split_d = 1'b0;
            if (req_size == SZ_RSVD) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_SIZE;
            end else if (misal && !SPLIT_EN) begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_MISALIGN;
            end else begin
                state_d    = ST_BEAT1;
                addr_d     = {req_addr[31:2], 2'b00};
                be_d       = al_lanes[3:0];
                wdata_d    = al_shifted[31:0];
                hi_be_d    = al_lanes[7:4];
                hi_wdata_d = al_shifted[63:32];
                split_d    = misal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            hi_wdata_q  <= 32'h0;
            hi_be_q     <= 4'h0;
            split_q     <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_be_q     <= hi_be_d;
            split_q     <= split_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign mem_valid = (state_q == ST_BEAT1) || (state_q == ST_BEAT2);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow; expectations follow STORE_MISALIGN_SPLIT_EN when defined.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_cmp = 0;
    int n_bad = 0;

    store_narrow dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                              input logic [31:0] wd);
        check({tag, ".valid"}, {31'h0, mem_valid}, 32'h1);
        check({tag, ".addr"},  mem_addr, a);
        check({tag, ".be"},    {28'h0, mem_be}, {28'h0, be});
        check({tag, ".wdata"}, mem_wdata, wd);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".valid"}, {31'h0, mem_valid}, 32'h0);
        check({tag, ".addr"},  mem_addr, 32'h0);
        check({tag, ".wdata"}, mem_wdata, 32'h0);
        check({tag, ".be"},    {28'h0, mem_be}, 32'h0);
        check({tag, ".errv"},  {31'h0, err_valid}, 32'h0);
        check({tag, ".errc"},  {30'h0, err_code}, 32'h0);
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        mem_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check_idle_zero("reset");

        // byte store into lane 2
        send(32'h0000_100A, 32'h0000_00AB, 2'b00); mem_ready = 1'b1;
        tick(); req_valid = 1'b0; #1;
        check_beat("byte", 32'h0000_1008, 4'b0100, 32'h00AB_0000);
        tick();
        check("byte.done", {31'h0, mem_valid}, 32'h0);

        // byte at top lane with upper data bits that must be dropped
        send(32'h0000_7003, 32'hFFFF_FF5A, 2'b00);
        tick(); req_valid = 1'b0; #1;
        check_beat("byte3", 32'h0000_7000, 4'b1000, 32'h5A00_0000);
        tick();

        // halfword with memory stalled for three cycles
        send(32'h0000_2002, 32'hFFFF_8000, 2'b01); mem_ready = 1'b0;
        tick(); req_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check_beat("half_stall", 32'h0000_2000, 4'b1100, 32'h8000_0000);
            check("half_stall.ready", {31'h0, req_ready}, 32'h0);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("half_release.ready", {31'h0, req_ready}, 32'h1);
        tick();
        check("half.done", {31'h0, mem_valid}, 32'h0);

        // back-to-back words, no bubble
        send(32'h0000_3000, 32'hDEAD_BEEF, 2'b10);
        tick();
        send(32'h0000_3004, 32'h0123_4567, 2'b10); #1;
        check("b2b.ready", {31'h0, req_ready}, 32'h1);
        check_beat("b2b0", 32'h0000_3000, 4'b1111, 32'hDEAD_BEEF);
        tick(); req_valid = 1'b0; #1;
        check_beat("b2b1", 32'h0000_3004, 4'b1111, 32'h0123_4567);
        tick();
        check("b2b.done", {31'h0, mem_valid}, 32'h0);

        // misaligned word
        send(32'h0000_4001, 32'h1122_3344, 2'b10);
        tick(); req_valid = 1'b0; #1;
`ifdef STORE_MISALIGN_SPLIT_EN
        check_beat("mis_b1", 32'h0000_4000, 4'b1110, 32'h2233_4400);
        check("mis_b1.ready", {31'h0, req_ready}, 32'h0);
        check("mis_b1.errv", {31'h0, err_valid}, 32'h0);
        tick();
        check_beat("mis_b2", 32'h0000_4004, 4'b0001, 32'h0000_0011);
        check("mis_b2.ready", {31'h0, req_ready}, 32'h1);
        tick();
        check("mis.done", {31'h0, mem_valid}, 32'h0);
        check("mis.errv", {31'h0, err_valid}, 32'h0);

        // halfword straddling the top of the address space
        send(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
        tick(); req_valid = 1'b0; #1;
        check_beat("wrap_b1", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        tick();
        check_beat("wrap_b2", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
        tick();

        // reset during the first beat of a split drops the second beat
        send(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01); mem_ready = 1'b0;
        tick(); req_valid = 1'b0; #1;
        check("rstsplit.valid", {31'h0, mem_valid}, 32'h1);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1; #1;
        check_idle_zero("rstsplit");
        mem_ready = 1'b1;
        tick();
        check("rstsplit.nobeat", {31'h0, mem_valid}, 32'h0);
`else
        check("mis.valid", {31'h0, mem_valid}, 32'h0);
        check("mis.errv", {31'h0, err_valid}, 32'h1);
        check("mis.errc", {30'h0, err_code}, 32'h1);
        tick();
        check("mis.errv_end", {31'h0, err_valid}, 32'h0);
        check("mis.errc_end", {30'h0, err_code}, 32'h0);
`endif

        // reset while a legal beat is stalled
        send(32'h0000_5002, 32'h0000_1234, 2'b01); mem_ready = 1'b0;
        tick(); req_valid = 1'b0; #1;
        check_beat("rstbeat", 32'h0000_5000, 4'b1100, 32'h1234_0000);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1; #1;
        check_idle_zero("rstbeat");
        mem_ready = 1'b1;
        tick();
        check("rstbeat.nobeat", {31'h0, mem_valid}, 32'h0);

        // reserved size
        send(32'h0000_6000, 32'hCAFE_F00D, 2'b11);
        tick(); req_valid = 1'b0; #1;
        check("rsvd.valid", {31'h0, mem_valid}, 32'h0);
        check("rsvd.errv", {31'h0, err_valid}, 32'h1);
        check("rsvd.errc", {30'h0, err_code}, 32'h2);
        check("rsvd.ready", {31'h0, req_ready}, 32'h1);
        tick();
        check("rsvd.errv_end", {31'h0, err_valid}, 32'h0);
        check("rsvd.errc_end", {30'h0, err_code}, 32'h0);
        check("rsvd.idle", {31'h0, mem_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_narrow.md
STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset is synchronous and active-low.
REQ-003 SHALL have port req_valid  input  1  store request present.
REQ-004 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready at a clk edge.
REQ-005 SHALL have port req_addr  input  32  byte address of store.
REQ-006 SHALL have port req_data  input  32  register value, right-justified (inverse of sign extension: only low 8/16/32 bits stored).
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port mem_valid  output  1  memory beat present.
REQ-009 SHALL have port mem_ready  input  1  beat completes when mem_valid && mem_ready.
REQ-010 SHALL have port mem_addr  output  32  word-aligned address, bits [1:0] always 00.
REQ-011 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-012 SHALL have port mem_be  output  4  byte enables, bit n = byte lane n.
REQ-013 SHALL have port err_valid  output  1  one-cycle error pulse.
REQ-014 SHALL have port err_code  output  2  01 misaligned, 10 reserved size, 00 otherwise.

Function
REQ-015 SHALL define off = req_addr[1:0], mask = 0001/0011/1111 for byte/half/word, lanes8 = mask << off (8-bit).
REQ-016 SHALL drive first beat: mem_addr = {addr[31:2],00}, mem_be = lanes8[3:0], mem_wdata = req_data << 8*off truncated to 32 bits; disabled lanes zero.
REQ-017 SHALL treat a request as misaligned when halfword with off[0]=1, or word with off != 00.
REQ-018 SHALL implement states IDLE, BEAT1, BEAT2; mem_valid = 1 exactly in BEAT1/BEAT2.
REQ-019 SHALL set req_ready = IDLE || (mem_ready && (BEAT2 || (BEAT1 && no second beat pending))) -- combinational on mem_ready.
REQ-020 SHALL present a legal accepted request in BEAT1 the cycle after acceptance (latency 1).
REQ-021 SHALL hold mem_addr/mem_wdata/mem_be stable while mem_valid && !mem_ready.
REQ-022 SHALL, on beat completion with a new accepted request in the same cycle, go directly to BEAT1 with the new beat (no bubble); otherwise IDLE.
REQ-023 SHALL accept a req_size=11 request, issue no beat, pulse err_valid with err_code=10 one cycle after acceptance, and be in IDLE.
REQ-024 SHALL keep err_code = 00 whenever err_valid = 0.

Reset
REQ-025 SHALL, when rst_n=0 at a clk edge, enter IDLE and clear mem_valid, mem_addr, mem_wdata, mem_be, err_valid, err_code to 0; req_ready reads 1 the first cycle after reset.
REQ-026 SHALL discard any in-flight beat or pending second beat on reset; no beat is issued afterwards for it.

Configuration
REQ-027 SHALL honour macro STORE_MISALIGN_SPLIT_EN.
REQ-028 SHALL, without the macro, accept a misaligned request, issue no beat, pulse err_valid with err_code=01 one cycle after acceptance.
REQ-029 SHALL, with the macro, split a misaligned request into BEAT1 (REQ-016) then BEAT2: mem_addr = {addr[31:2],00}+4 modulo 2^32, mem_be = lanes8[7:4], mem_wdata = req_data >> 8*(4-off); no error reported.
REQ-030 SHALL, with the macro, enter BEAT2 only after BEAT1 completes, and keep req_ready low during BEAT1 of a split.

Structure
REQ-031 SHALL place size encodings, err_code values, and the state enum in shared package store_pkg.
REQ-032 SHALL use one combinational sub-module store_lane_align (size, off, data -> 64-bit shifted data, 8-bit lanes) for all beat computation.

Verification
REQ-033 SHALL cover: byte store addr=0x100A data=0x000000AB, mem_ready=1 -> one beat addr=0x1008 be=0100 wdata=0x00AB0000, one cycle after acceptance.
REQ-034 SHALL cover: halfword addr=0x2002 data=0xFFFF8000 with mem_ready held 0 three cycles -> outputs stable addr=0x2000 be=1100 wdata=0x80000000, req_ready=0 until completion.
REQ-035 SHALL cover: back-to-back word stores 0x3000/0x3004, mem_ready=1 -> two consecutive beats, no idle cycle.
REQ-036 SHALL cover: word addr=0x4001 data=0x11223344 -> without macro: no beat, err_valid/err_code=01; with macro: beat1 addr=0x4000 be=1110 wdata=0x22334400, beat2 addr=0x4004 be=0001 wdata=0x00000011.
REQ-037 SHALL cover: macro on, halfword addr=0xFFFFFFFF -> beat2 addr=0x00000000 be=0001; rst_n=0 during beat1 -> no beat2, all outputs 0.
REQ-038 SHALL cover: req_size=11 -> no beat, err_valid one cycle with err_code=10, state IDLE.
